// File: rtl/switch_allocator.sv
// Separable per-output switch allocator for a wormhole crossbar: round-robin
// arbitration among requesters, with the output locked to its winner until the tail flit.
module switch_allocator #(
  parameter int INPUT_NUM  = 4,
  parameter int OUTPUT_NUM = 4,
  localparam int SEL_SIZE  = $clog2(INPUT_NUM),
  localparam int PORT_SIZE = $clog2(OUTPUT_NUM)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [INPUT_NUM-1:0]                  req_i,
  input  logic [INPUT_NUM-1:0][PORT_SIZE-1:0]   out_port_i,
  input  logic [INPUT_NUM-1:0]                  tail_i,
  input  logic [OUTPUT_NUM-1:0]                 out_ready_i,
  output logic [INPUT_NUM-1:0]                  grant_o,
  output logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]   sel_o,
  output logic [OUTPUT_NUM-1:0]                 valid_o
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]          state   [OUTPUT_NUM];
  logic [SEL_SIZE-1:0] owner   [OUTPUT_NUM];
  logic [SEL_SIZE-1:0] ptr     [OUTPUT_NUM];
  logic [SEL_SIZE-1:0] win     [OUTPUT_NUM];
  logic [SEL_SIZE-1:0] nxt_ptr [OUTPUT_NUM];
  logic [OUTPUT_NUM-1:0] gnt;

  always_comb begin
    logic [INPUT_NUM-1:0] cand;
    logic                 found;
    int unsigned          idx;
    grant_o = '0;
    gnt     = '0;
    for (int unsigned o = 0; o < OUTPUT_NUM; o++) begin
      win[o]     = '0;
      nxt_ptr[o] = '0;
      cand       = '0;
      found      = 1'b0;
      idx        = 0;
      // Reset gates candidates so grant_o drops immediately, without a clock.
      for (int unsigned i = 0; i < INPUT_NUM; i++)
        cand[i] = rst && req_i[i] && out_ready_i[o] && (out_port_i[i] == PORT_SIZE'(o));
      if (state[o] == LOCKED) begin
        gnt[o] = cand[owner[o]];
        win[o] = owner[o];
      end else begin
        for (int unsigned j = 0; j < INPUT_NUM; j++) begin
          idx = (32'(ptr[o]) + j) % INPUT_NUM;
          if (!found && cand[SEL_SIZE'(idx)]) begin
            found  = 1'b1;
            gnt[o] = 1'b1;
            win[o] = SEL_SIZE'(idx);
          end
        end
      end
      nxt_ptr[o] = SEL_SIZE'((32'(win[o]) + 1) % INPUT_NUM);
      if (gnt[o])
        grant_o[win[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned o = 0; o < OUTPUT_NUM; o++) begin
        state[o] <= IDLE;
        owner[o] <= '0;
        ptr[o]   <= '0;
      end
      sel_o   <= '0;
      valid_o <= '0;
    end else begin
      for (int unsigned o = 0; o < OUTPUT_NUM; o++) begin
        valid_o[o] <= gnt[o];
        sel_o[o]   <= gnt[o] ? win[o] : '0;
        if (gnt[o]) begin
          if (tail_i[win[o]]) begin
            state[o] <= IDLE;
            ptr[o]   <= nxt_ptr[o];
          end else begin
            state[o] <= LOCKED;
            owner[o] <= win[o];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed packet scenarios followed by random traffic,
// all compared against a packet-level reference model of the allocator.
module tb_switch_allocator;

  localparam int NI = 4;
  localparam int NO = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NI-1:0]        req;
  logic [NI-1:0][1:0]   port;
  logic [NI-1:0]        tail;
  logic [NO-1:0]        ready;
  logic [NI-1:0]        grant;
  logic [NO-1:0][1:0]   sel;
  logic [NO-1:0]        valid;

  int checks = 0;
  int errors = 0;

  // Reference model state: lock flag, owner and round-robin pointer per output.
  int          m_locked [NO];
  int          m_own    [NO];
  int          m_ptr    [NO];
  int          e_gnt    [NO];
  int          e_win    [NO];
  logic [NI-1:0]      e_grant;
  logic [NO-1:0]      p_valid;
  logic [NO-1:0][1:0] p_sel;

  switch_allocator #(.INPUT_NUM(NI), .OUTPUT_NUM(NO)) dut (
    .clk(clk), .rst(rst), .req_i(req), .out_port_i(port), .tail_i(tail),
    .out_ready_i(ready), .grant_o(grant), .sel_o(sel), .valid_o(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < NO; o++) begin
      m_locked[o] = 0;
      m_own[o]    = 0;
      m_ptr[o]    = 0;
    end
    p_valid = '0;
    p_sel   = '0;
  endtask

  task automatic model_eval();
    e_grant = '0;
    for (int o = 0; o < NO; o++) begin
      e_gnt[o] = 0;
      e_win[o] = 0;
      if (ready[o]) begin
        if (m_locked[o] != 0) begin
          if (req[m_own[o]] && port[m_own[o]] == o) begin
            e_gnt[o] = 1;
            e_win[o] = m_own[o];
          end
        end else begin
          for (int j = 0; j < NI; j++) begin
            int i;
            i = (m_ptr[o] + j) % NI;
            if (e_gnt[o] == 0 && req[i] && port[i] == o) begin
              e_gnt[o] = 1;
              e_win[o] = i;
            end
          end
        end
      end
      if (e_gnt[o] != 0) e_grant[e_win[o]] = 1'b1;
    end
  endtask

  task automatic model_commit();
    for (int o = 0; o < NO; o++) begin
      p_valid[o] = (e_gnt[o] != 0);
      p_sel[o]   = (e_gnt[o] != 0) ? 2'(e_win[o]) : 2'd0;
      if (e_gnt[o] != 0) begin
        if (tail[e_win[o]]) begin
          m_locked[o] = 0;
          m_ptr[o]    = (e_win[o] + 1) % NI;
        end else begin
          m_locked[o] = 1;
          m_own[o]    = e_win[o];
        end
      end
    end
  endtask

  // One clock: inputs already driven; check at negedge, then advance past posedge.
  task automatic step(input string tag);
    @(negedge clk);
    model_eval();
    chk({tag, ":grant"}, 32'(grant), 32'(e_grant));
    chk({tag, ":valid"}, 32'(valid), 32'(p_valid));
    chk({tag, ":sel"},   32'(sel),   32'(p_sel));
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, ":rst_grant"}, 32'(grant), 32'h0);
    chk({tag, ":rst_valid"}, 32'(valid), 32'h0);
    chk({tag, ":rst_sel"},   32'(sel),   32'h0);
    model_reset();
    @(posedge clk);
    #1;
    req = '0;
    rst = 1'b1;
  endtask

  initial begin
    rst   = 1'b0;
    req   = '1;
    tail  = '1;
    ready = '1;
    for (int i = 0; i < NI; i++) port[i] = 2'(i);
    model_reset();
    #3;
    chk("r029_grant", 32'(grant), 32'h0);
    chk("r029_valid", 32'(valid), 32'h0);
    chk("r029_sel",   32'(sel),   32'h0);
    @(posedge clk);
    #1;
    req = '0;
    rst = 1'b1;

    // All four inputs to distinct outputs.
    req = 4'b1111; tail = 4'b1111; ready = 4'b1111;
    for (int i = 0; i < NI; i++) port[i] = 2'(i);
    #2 chk("r030_grant", 32'(grant), 32'hF);
    step("r030");
    chk("r030_valid", 32'(valid), 32'hF);
    chk("r030_sel",   32'(sel),   32'hE4);

    // Three single-flit requesters on output 2.
    req = 4'b0111; port[0] = 2'd2; port[1] = 2'd2; port[2] = 2'd2;
    for (int k = 0; k < 3; k++) begin
      #2 chk("r031_grant", 32'(grant), 32'(1 << k));
      step("r031");
      chk("r031_sel2", 32'(sel[2]), 32'(k));
    end

    // Three-flit packet from input 1 on output 0 while input 3 waits.
    req = 4'b1010; port[1] = 2'd0; port[3] = 2'd0; tail = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) tail[1] = 1'b1;
      #2 chk("r032_owner", 32'(grant), 32'h2);
      step("r032");
    end
    req = 4'b1000;
    #2 chk("r032_next", 32'(grant), 32'h8);
    step("r032b");

    // Locked packet stalled by missing downstream credit.
    req = 4'b1100; port[2] = 2'd0; port[3] = 2'd0; tail = 4'b1000;
    step("r033_f1");
    ready[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #2 chk("r033_stall", 32'(grant), 32'h0);
      step("r033_stall");
      chk("r033_valid0", 32'(valid[0]), 32'h0);
    end
    ready[0] = 1'b1;
    #2 chk("r033_f2", 32'(grant), 32'h4);
    step("r033_f2");
    tail[2] = 1'b1;
    #2 chk("r033_f3", 32'(grant), 32'h4);
    step("r033_f3");
    step("r033_after");

    // Reset mid-packet releases the lock and rewinds the pointer.
    req = 4'b0100; port[2] = 2'd1; tail = 4'b0000;
    step("r034_lock");
    pulse_reset("r034");
    req = 4'b0101; port[0] = 2'd1; port[2] = 2'd1; tail = 4'b1111;
    #2 chk("r034_grant", 32'(grant), 32'h1);
    step("r034");

    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      req   = 4'($urandom);
      tail  = 4'($urandom) | 4'($urandom);
      ready = 4'($urandom) | 4'($urandom);
      for (int i = 0; i < NI; i++) port[i] = 2'($urandom_range(0, NO - 1));
      if (n % 97 == 50) pulse_reset("rnd");
      else step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
